display_scan_ctrl: RTL and testbench

//  Time-multiplexed scanner that drives a bank of common 7-segment digits.

---
 rtl/disp_pkg.sv | 19 +
 rtl/lz_blank_mask.sv | 22 ++
 rtl/display_scan_ctrl.sv | 107 ++++++++++
 tb/tb_display_scan_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package disp_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Map a logical "digit on" to the pin level.
  function automatic logic en_polarity(input logic on,
                                       input bit   act_low);
    return on ^ act_low;
  endfunction

endpackage

// File: rtl/lz_blank_mask.sv
// Leading-zero blank mask: digit k>0 is blanked when it and
// every more significant digit are zero.
module lz_blank_mask #(
  parameter int N_DIGITS = 4
) (
  input  logic [4*N_DIGITS-1:0] disp_i,
  input  logic                  en_i,
  output logic [N_DIGITS-1:0]   mask_o
);

  logic hi_zero;

  always_comb begin
    hi_zero = 1'b1;
    mask_o  = '0;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      hi_zero   = hi_zero & (disp_i[4*k +: 4] == 4'h0);
      mask_o[k] = en_i & hi_zero;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scanner with ghost gap, leading-zero
// blanking and frame-aligned display updates.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int         N_DIGITS   = 4,
  parameter int         DIV_COUNT  = 50000,
  parameter int         GAP_CYC    = 64,
  parameter int         EN_ACT_LOW = 1,
  parameter logic [3:0] BLANK_CODE = disp_pkg::BLANK_CODE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4*N_DIGITS-1:0]        value,
  input  logic                         load,
  input  logic                         blank_lz,
  output logic [3:0]                   bcd_out,
  output logic [N_DIGITS-1:0]          dig_en,
  output logic [clog2(N_DIGITS)-1:0]   dig_idx,
  output logic                         frame_start
);

  localparam int IW      = clog2(N_DIGITS);
  localparam int CW      = clog2(DIV_COUNT);
  localparam bit ACT_LOW = (EN_ACT_LOW != 0);
  localparam logic [N_DIGITS-1:0] EN_OFF = {N_DIGITS{ACT_LOW}};

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pend_q, pend_d;
  logic [4*N_DIGITS-1:0] disp_q, disp_d;
  logic                  lz_q, lz_d;
  logic                  wrap, commit;
  logic [N_DIGITS-1:0]   mask;
  logic [N_DIGITS-1:0]   en_q, en_d;
  logic [3:0]            bcd_q, bcd_d, nib;
  logic                  fs_q, fs_d;

  always_comb begin
    wrap   = (cnt_q == CW'(DIV_COUNT - 1));
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    idx_d  = idx_q;
    commit = 1'b0;
    if (wrap) begin
      if (idx_q == IW'(N_DIGITS - 1)) begin
        idx_d  = '0;
        commit = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
    // Commit sees the pending word from before any coincident load.
    pend_d = load ? value : pend_q;
    disp_d = commit ? pend_q : disp_q;
    lz_d   = commit ? blank_lz : lz_q;
  end

  lz_blank_mask #(
    .N_DIGITS (N_DIGITS)
  ) u_mask (
    .disp_i (disp_d),
    .en_i   (lz_d),
    .mask_o (mask)
  );

  // Outputs are computed from next-state so they register cleanly.
  always_comb begin
    nib  = BLANK_CODE;
    en_d = EN_OFF;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_d == IW'(k))
        nib = mask[k] ? BLANK_CODE : disp_d[4*k +: 4];
      en_d[k] = en_polarity((cnt_d >= CW'(GAP_CYC)) &&
                            (idx_d == IW'(k)), ACT_LOW);
    end
    bcd_d = (cnt_d == '0) ? nib : bcd_q;
    fs_d  = (cnt_d == '0) && (idx_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= '0;
      disp_q <= '0;
      lz_q   <= 1'b0;
      bcd_q  <= BLANK_CODE;
      en_q   <= EN_OFF;
      fs_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      lz_q   <= lz_d;
      bcd_q  <= bcd_d;
      en_q   <= en_d;
      fs_q   <= fs_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign dig_en      = en_q;
  assign dig_idx     = idx_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: time-based reference model,
// per-cycle compare, directed frames and random traffic.
module tb_display_scan_ctrl;

  localparam int N = 4;
  localparam int D = 8;
  localparam int G = 2;
  localparam int F = N * D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  bcd_out;
  logic [3:0]  dig_en;
  logic [1:0]  dig_idx;
  logic        frame_start;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  int          t_m;
  logic [15:0] pend_m, disp_m;
  logic        lz_m;
  logic [3:0]  bcd_m;
  logic [3:0]  e_en;
  int          last_fs;

  display_scan_ctrl #(
    .N_DIGITS   (N),
    .DIV_COUNT  (D),
    .GAP_CYC    (G),
    .EN_ACT_LOW (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .load        (load),
    .blank_lz    (blank_lz),
    .bcd_out     (bcd_out),
    .dig_en      (dig_en),
    .dig_idx     (dig_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Nibble seen in slot k: blank above the highest nonzero digit.
  function automatic logic [3:0] shown(logic [15:0] d, logic lz,
                                       int k);
    int top;
    top = 0;
    for (int j = 0; j < N; j++)
      if (d[4*j +: 4] != 4'h0) top = j;
    if (lz && k > top) return 4'hF;
    return d[4*k +: 4];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: t_m = edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t_m    = 0;
      pend_m = '0;
      disp_m = '0;
      lz_m   = 1'b0;
      bcd_m  = 4'hF;
    end else begin
      t_m++;
      if (t_m % F == 0) begin
        disp_m = pend_m;
        lz_m   = blank_lz;
      end
      if (load) pend_m = value;
      if (t_m % D == 0)
        bcd_m = shown(disp_m, lz_m, (t_m / D) % N);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      last_fs = -1;
    end else if (chk_on) begin
      e_en = (t_m % D >= G) ? ~(4'b0001 << ((t_m / D) % N)) : 4'hF;
      chk("dig_idx", 32'(dig_idx), 32'((t_m / D) % N));
      chk("dig_en", 32'(dig_en), 32'(e_en));
      chk("bcd_out", 32'(bcd_out), 32'(bcd_m));
      chk("frame_start", 32'(frame_start),
          32'(t_m > 0 && t_m % F == 0));
      chk("en_onehot", 32'($countones(~dig_en) <= 1), 32'd1);
      if (frame_start) begin
        if (last_fs >= 0) chk("fs_period", t_m - last_fs, F);
        last_fs = t_m;
      end
    end
  end

  task automatic wait_frame(string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2 * F + 2 && !got; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (frame_start) got = 1'b1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: frame_start timeout at %0t", nm, $time);
    end
  endtask

  // Starts on the frame_start cycle; ends on the frame's last cycle.
  task automatic check_frame(logic [15:0] e, string nm);
    logic [3:0] en_x;
    chk({nm, " fs"}, 32'(frame_start), 32'd1);
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < D; c++) begin
        en_x = (c >= G) ? ~(4'b0001 << k) : 4'hF;
        chk({nm, " bcd"}, 32'(bcd_out), 32'(e[4*k +: 4]));
        chk({nm, " en"}, 32'(dig_en), 32'(en_x));
        if (!(k == N - 1 && c == D - 1)) @(negedge clk);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst bcd", 32'(bcd_out), 32'hF);
    chk("rst en", 32'(dig_en), 32'hF);
    chk("rst idx", 32'(dig_idx), 32'd0);
    chk("rst fs", 32'(frame_start), 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    repeat (13) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst bcd", 32'(bcd_out), 32'hF);
    chk("midrst en", 32'(dig_en), 32'hF);
    chk("midrst idx", 32'(dig_idx), 32'd0);
    chk("midrst fs", 32'(frame_start), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    value = 16'h1234;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("post idx", 32'(dig_idx), 32'd0);
    @(negedge clk);
    chk("post en", 32'(dig_en), 32'hE);

    wait_frame("f1234");
    check_frame(16'h1234, "f1234");

    repeat (3) @(negedge clk);
    value = 16'h0050;
    blank_lz = 1'b1;
    load = 1'b1;
    wait_frame("f0050lz");
    check_frame(16'hFF50, "f0050lz");
    blank_lz = 1'b0;
    wait_frame("f0050");
    check_frame(16'h0050, "f0050");

    repeat (3) @(negedge clk);
    value = 16'h0000;
    blank_lz = 1'b1;
    load = 1'b1;
    wait_frame("f0000");
    check_frame(16'hFFF0, "f0000");

    repeat (3) @(negedge clk);
    value = 16'h1111;
    load = 1'b1;
    wait_frame("f1111");
    check_frame(16'h1111, "f1111");
    wait_frame("fB");
    repeat (2 * D + 3) @(negedge clk);
    value = 16'h2222;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("slot2 hold", 32'(bcd_out), 32'h1);
    repeat (9) @(negedge clk);
    chk("slot3 hold", 32'(bcd_out), 32'h1);
    wait_frame("f2222");
    check_frame(16'h2222, "f2222");
    value = 16'h3333;
    load = 1'b1;
    wait_frame("fcommit");
    check_frame(16'h2222, "fcommit");
    wait_frame("f3333");
    check_frame(16'h3333, "f3333");

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      load = ($urandom % 6 == 0);
      blank_lz = 1'($urandom % 2);
      for (int j = 0; j < N; j++)
        value[4*j +: 4] = ($urandom % 4 == 0) ? 4'h0
                                              : 4'($urandom);
    end
    @(negedge clk);
    load = 1'b0;
    repeat (2 * F) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
